cic_decim_comb_section: RTL and testbench
=========================================

// Module: cic_decim_comb_section
// PURPOSE
//  Back end of the CIC decimator: keeps every R-th valid integrator-chain sample, then
//  passes the kept samples through CIC_N cascaded comb stages (y = x - x[n-CIC_M]).
//  The rate is fixed at CIC_R, or run-time programmable when VARIABLE_RATE=1.
//  It sits between the integrator chain and the output register of the CIC filter.
// PARAMETERS
//  DATA_W        32  width of data in, data out and every comb stage (no pruning)
//  RATE_DW       32  width of the rate port
//  CIC_R         10  decimation ratio; when VARIABLE_RATE=1 it is the max ratio and the reset rate
//  CIC_N          7  number of comb stages (>=1)
//  CIC_M          1  differential delay of each comb stage, in decimated samples (>=1)
//  VARIABLE_RATE  1  1: rate port active; 0: rate port ignored, ratio fixed at CIC_R
// PORTS
//  clk                 in   1        clock; all state changes on the rising edge
//  reset               in   1        synchronous, active-high reset
//  s_axis_in_tdata     in   DATA_W   signed input sample (integrator chain output)
//  s_axis_in_tvalid    in   1        input sample valid (no backpressure)
//  s_axis_rate_tdata   in   RATE_DW  new decimation ratio
//  s_axis_rate_tvalid  in   1        load s_axis_rate_tdata as the new ratio
//  m_axis_out_tdata    out  DATA_W   signed decimated, comb-filtered sample
//  m_axis_out_tvalid   out  1        one-cycle pulse per output sample
// BEHAVIOUR
//  Reset: rate register = CIC_R, sample counter = 0, all comb delay lines = 0, all stage
//   data/valid registers = 0, m_axis_out_tdata = 0, m_axis_out_tvalid = 0.
//  Downsampler:
//   - The counter advances only on cycles with s_axis_in_tvalid=1.
//   - On a valid cycle with counter == R-1: register the sample, pulse the stage valid
//     on the next cycle and set the counter to 0. Otherwise increment the counter.
//   - So the R-th, 2R-th, ... valid samples after reset are kept. Latency is 1 cycle.
//  Rate load (VARIABLE_RATE=1 only):
//   - On s_axis_rate_tvalid=1: R <= rate_tdata and counter <= 0.
//   - Rate value 0 is loaded as 1; values > CIC_R are clamped to CIC_R.
//   - An input sample valid in the same cycle is discarded (not counted, not emitted).
//  Comb stage k (0..CIC_N-1):
//   - Stage 0 takes the downsampler output; stage k takes stage k-1.
//   - On input valid: out <= in - dly[CIC_M-1], dly shifts in `in`, and the output
//     valid pulses the next cycle. Latency is 1 cycle per stage.
//   - Without input valid, the delay line and data register hold and output valid = 0.
//  Arithmetic: two's-complement, modulo 2^DATA_W (wrap-around is intended; no saturation).
//  Output: the last comb stage drives m_axis_out_tdata, which holds its value between pulses.
//   Total latency from the kept input sample to m_axis_out_tvalid is 1 + CIC_N cycles.
//  Input valid may be asserted every cycle; arbitrary gaps are allowed.
//  Reset asserted mid-stream clears all state within that cycle; in-flight samples are dropped.
// TESTING  (DATA_W=16, CIC_R=4, CIC_N=2, CIC_M=1, VARIABLE_RATE=1 unless noted)
//  1 Hold reset 3 cycles, inputs toggling -> out_tdata=0, out_tvalid=0 throughout.
//  2 Ramp x=0,1,2,... valid every cycle -> downsampler keeps 3,7,11,15; comb1 gives 3,4,4,4;
//    output is 3,1,0,0; out_tvalid pulses every 4 cycles, 3 cycles after samples 3,7,...
//  3 Same ramp with tvalid on every 3rd cycle only -> identical output values; a pulse
//    follows every 4th valid sample (every 12 cycles).
//  4 Load rate 2 mid-stream, with tvalid high in that cycle -> that sample is dropped;
//    the next output pulse follows the 2nd valid sample after the load. Loading 0 acts as
//    1 (every sample kept); loading 9 acts as 4.
//  5 Wrap: kept samples 0x7FFF then 0x8000 (N=1) -> outputs 0x7FFF then 0x0001.
//    Kept 0x8000 then 0x7FFF -> 0xFFFF.
//  6 Assert reset between two kept samples -> no stale pulse after reset. The first
//    post-reset output uses zeroed delay lines and the rate is back to 4.

Source files
------------

// File: rtl/cic_decim_comb_section.sv
// CIC decimator back end: keeps every R-th valid sample from the integrator
// chain, then runs the kept samples through CIC_N cascaded comb stages
// (y = x - x[n-CIC_M]). The ratio is fixed at CIC_R, or run-time loadable
// (clamped to 1..CIC_R) when VARIABLE_RATE is set.
module cic_decim_comb_section #(
  parameter int DATA_W        = 32,
  parameter int RATE_DW       = 32,
  parameter int CIC_R         = 10,
  parameter int CIC_N         = 7,
  parameter int CIC_M         = 1,
  parameter int VARIABLE_RATE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  s_axis_in_tdata,
  input  logic                      s_axis_in_tvalid,
  input  logic        [RATE_DW-1:0] s_axis_rate_tdata,
  input  logic                      s_axis_rate_tvalid,
  output logic signed [DATA_W-1:0]  m_axis_out_tdata,
  output logic                      m_axis_out_tvalid
);

  localparam logic [RATE_DW-1:0] RATE_MAX = RATE_DW'(CIC_R);
  localparam logic [RATE_DW-1:0] RATE_MIN = RATE_DW'(1);

  logic [RATE_DW-1:0] rate_q;
  logic [RATE_DW-1:0] rate_eff;
  logic [RATE_DW-1:0] rate_load;
  logic               rate_wr;
  logic [RATE_DW-1:0] cnt_q;
  logic [DATA_W-1:0]  ds_data_q;
  logic               ds_valid_q;

  // Comb chain plumbing: index 0 is the downsampler, index k+1 is stage k
  logic [DATA_W-1:0]  chain_data  [CIC_N+1];
  logic               chain_valid [CIC_N+1];

  // A fixed-rate build ignores the rate port entirely
  assign rate_wr  = (VARIABLE_RATE != 0) && s_axis_rate_tvalid;
  assign rate_eff = (VARIABLE_RATE != 0) ? rate_q : RATE_MAX;

  // Clamp an incoming ratio into the legal range 1..CIC_R
  always_comb begin
    rate_load = s_axis_rate_tdata;
    if (s_axis_rate_tdata == '0) begin
      rate_load = RATE_MIN;
    end else if (s_axis_rate_tdata > RATE_MAX) begin
      rate_load = RATE_MAX;
    end
  end

  // Downsampler: count valid samples and keep the one that closes each group of R;
  // a rate load restarts the count and swallows any sample arriving with it
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q     <= RATE_MAX;
      cnt_q      <= '0;
      ds_data_q  <= '0;
      ds_valid_q <= 1'b0;
    end else begin
      ds_valid_q <= 1'b0;
      if (rate_wr) begin
        rate_q <= rate_load;
        cnt_q  <= '0;
      end else if (s_axis_in_tvalid) begin
        if (cnt_q == rate_eff - RATE_MIN) begin
          ds_data_q  <= s_axis_in_tdata;
          ds_valid_q <= 1'b1;
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_q + RATE_MIN;
        end
      end
    end
  end

  assign chain_data[0]  = ds_data_q;
  assign chain_valid[0] = ds_valid_q;

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    logic [DATA_W-1:0] dly_q [CIC_M];
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Comb stage: on each valid input subtract the sample CIC_M steps back
    // (modulo 2^DATA_W) and shift the delay line; otherwise everything holds
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < CIC_M; i++) begin
          dly_q[i] <= '0;
        end
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= chain_valid[k];
        if (chain_valid[k]) begin
          data_q   <= chain_data[k] - dly_q[CIC_M-1];
          dly_q[0] <= chain_data[k];
          for (int i = 1; i < CIC_M; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end
    end

    assign chain_data[k+1]  = data_q;
    assign chain_valid[k+1] = valid_q;
  end

  assign m_axis_out_tdata  = chain_data[CIC_N];
  assign m_axis_out_tvalid = chain_valid[CIC_N];

endmodule

// File: tb/tb_cic_decim_comb_section.sv
// Self-checking bench for cic_decim_comb_section (DATA_W=16, R=4, N=2, M=1).
// The reference model keeps the list of kept samples and forms each output
// directly as the N-th order difference sum_i (-1)^i C(N,i) x[j-i*M].
module tb_cic_decim_comb_section;

  localparam int DW   = 16;
  localparam int RDW  = 32;
  localparam int R    = 4;
  localparam int N    = 2;
  localparam int M    = 1;

  logic                  clk;
  logic                  reset;
  logic signed [DW-1:0]  s_axis_in_tdata;
  logic                  s_axis_in_tvalid;
  logic        [RDW-1:0] s_axis_rate_tdata;
  logic                  s_axis_rate_tvalid;
  logic signed [DW-1:0]  m_axis_out_tdata;
  logic                  m_axis_out_tvalid;

  cic_decim_comb_section #(
    .DATA_W(DW), .RATE_DW(RDW), .CIC_R(R), .CIC_N(N), .CIC_M(M), .VARIABLE_RATE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_axis_in_tdata(s_axis_in_tdata),
    .s_axis_in_tvalid(s_axis_in_tvalid),
    .s_axis_rate_tdata(s_axis_rate_tdata),
    .s_axis_rate_tvalid(s_axis_rate_tvalid),
    .m_axis_out_tdata(m_axis_out_tdata),
    .m_axis_out_tvalid(m_axis_out_tvalid)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] y;
  } exp_t;

  int            compared   = 0;
  int            mismatched = 0;
  int            edge_no    = 0;
  int            m_rate     = R;
  int            m_cnt      = 0;
  logic [DW-1:0] kept [$];
  exp_t          pend [$];
  logic          exp_valid  = 1'b0;
  logic [DW-1:0] exp_data   = '0;

  // N-th order difference of the newest kept sample, modulo 2^DW
  function automatic logic [DW-1:0] comb_out();
    longint acc = 0;
    longint c   = 1;
    int     j   = kept.size() - 1;
    for (int i = 0; i <= N; i++) begin
      if (j - i * M >= 0) begin
        if (i % 2 == 0) acc = acc + c * longint'(kept[j - i * M]);
        else            acc = acc - c * longint'(kept[j - i * M]);
      end
      c = c * (N - i) / (i + 1);
    end
    return acc[DW-1:0];
  endfunction

  // Apply one cycle of stimulus, advance the model at the edge, settle 1 time unit
  task automatic drive(input logic rst, input logic v, input logic [DW-1:0] d,
                       input logic rv, input logic [RDW-1:0] rd);
    reset              = rst;
    s_axis_in_tvalid   = v;
    s_axis_in_tdata    = d;
    s_axis_rate_tvalid = rv;
    s_axis_rate_tdata  = rd;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      kept.delete();
      pend.delete();
      m_cnt     = 0;
      m_rate    = R;
      exp_data  = '0;
    end else if (rv) begin
      if (rd == 0)           m_rate = 1;
      else if (rd > RDW'(R)) m_rate = R;
      else                   m_rate = int'(rd);
      m_cnt = 0;
    end else if (v) begin
      m_cnt++;
      if (m_cnt == m_rate) begin
        m_cnt = 0;
        kept.push_back(d);
        pend.push_back('{due: edge_no + N, y: comb_out()});
      end
    end
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_no) begin
      exp_valid = 1'b1;
      exp_data  = pend[0].y;
      void'(pend.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], DW'($urandom), ~i[0], RDW'($urandom_range(0, 9)));
      compared++;
      if (m_axis_out_tvalid !== 1'b0 || m_axis_out_tdata !== '0) begin
        mismatched++;
        $display("[TB] FAIL reset cyc=%0d: got v=%b d=%h, want v=0 d=0000",
                 i, m_axis_out_tvalid, m_axis_out_tdata);
      end
    end
  endtask

  task automatic test_ramp();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, i < 16, DW'(i), 1'b0, '0);
      compared++;
      if (m_axis_out_tvalid !== exp_valid || m_axis_out_tdata !== exp_data) begin
        mismatched++;
        $display("[TB] FAIL ramp cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                 i, m_axis_out_tvalid, m_axis_out_tdata, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_sparse();
    int x = 0;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 54; i++) begin
      if (i % 3 == 0) begin
        drive(1'b0, 1'b1, DW'(x), 1'b0, '0);
        x++;
      end else begin
        drive(1'b0, 1'b0, DW'($urandom), 1'b0, '0);
      end
      compared++;
      if (m_axis_out_tvalid !== exp_valid || m_axis_out_tdata !== exp_data) begin
        mismatched++;
        $display("[TB] FAIL sparse cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                 i, m_axis_out_tvalid, m_axis_out_tdata, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_rate_load();
    logic [RDW-1:0] loads [3];
    loads[0] = 2;
    loads[1] = 0;
    loads[2] = 9;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 14; i++) begin
        if (i == 3) drive(1'b0, 1'b1, DW'($urandom), 1'b1, loads[l]);
        else        drive(1'b0, 1'b1, DW'($urandom), 1'b0, '0);
        compared++;
        if (m_axis_out_tvalid !== exp_valid || m_axis_out_tdata !== exp_data) begin
          mismatched++;
          $display("[TB] FAIL rate_load%0d cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                   loads[l], i, m_axis_out_tvalid, m_axis_out_tdata, exp_valid, exp_data);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] seq [4];
    seq[0] = 16'h7FFF;
    seq[1] = 16'h8000;
    seq[2] = 16'h8000;
    seq[3] = 16'h7FFF;
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      drive(1'b0, 1'b0, '0, 1'b1, RDW'(1));
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, i < 2, (i < 2) ? seq[2*p + i] : '0, 1'b0, '0);
        compared++;
        if (m_axis_out_tvalid !== exp_valid || m_axis_out_tdata !== exp_data) begin
          mismatched++;
          $display("[TB] FAIL wrap%0d cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                   p, i, m_axis_out_tvalid, m_axis_out_tdata, exp_valid, exp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 24; i++) begin
      drive(i == 5, 1'b1, DW'($urandom), 1'b0, '0);
      compared++;
      if (m_axis_out_tvalid !== exp_valid || m_axis_out_tdata !== exp_data) begin
        mismatched++;
        $display("[TB] FAIL reset_mid cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                 i, m_axis_out_tvalid, m_axis_out_tdata, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_random();
    logic rst;
    logic rv;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      rv  = ($urandom_range(0, 39) == 0);
      drive(rst, $urandom_range(0, 3) != 0, DW'($urandom), rv,
            ($urandom_range(0, 7) == 0) ? RDW'($urandom) : RDW'($urandom_range(0, 6)));
      compared++;
      if (m_axis_out_tvalid !== exp_valid || m_axis_out_tdata !== exp_data) begin
        mismatched++;
        $display("[TB] FAIL random cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                 i, m_axis_out_tvalid, m_axis_out_tdata, exp_valid, exp_data);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    reset              = 1'b1;
    s_axis_in_tvalid   = 1'b0;
    s_axis_in_tdata    = '0;
    s_axis_rate_tvalid = 1'b0;
    s_axis_rate_tdata  = '0;
    test_reset();
    test_ramp();
    test_sparse();
    test_rate_load();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
